// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: arbiter state encoding and common constants.
package rv32_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   localparam logic [3:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/lat_counter.sv
// Fixed-latency down counter: load a start value, decrement to zero, flag zero.
module lat_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic [W-1:0] cnt,
   output logic         zero
);

   logic [W-1:0] cnt_r;

   // Counter register; load wins over decrement, and it saturates at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= {W{1'b0}};
      end else if (load) begin
         cnt_r <= load_val;
      end else if (dec && (cnt_r != {W{1'b0}})) begin
         cnt_r <= cnt_r - W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt  = cnt_r;
   assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between fetch and memory stages,
// data side first, with fixed-latency completion and branch-flush drop.
module mem_port_arbiter
   import rv32_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [3:0]        d_be,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_valid,
   output logic              d_stall,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_be,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MEM_LAT - 1);

   arb_state_t       state_r;
   arb_state_t       state_nxt_s;
   logic             kill_r;
   logic             kill_nxt_s;
   logic [CNT_W-1:0] cnt_s;
   logic             cnt_zero_s;
   logic             idle_s;
   logic             busy_i_s;
   logic             busy_d_s;
   logic             done_i_s;
   logic             done_d_s;
   logic             can_issue_s;
   logic             issue_d_s;
   logic             issue_i_s;
   logic             cnt_dec_s;

   lat_counter #(.W(CNT_W)) u_lat_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (issue_d_s | issue_i_s),
      .load_val (LOAD_VAL),
      .dec      (cnt_dec_s),
      .cnt      (cnt_s),
      .zero     (cnt_zero_s)
   );

   // State decode; an illegal encoding behaves as IDLE so the FSM recovers.
   always_comb begin
      idle_s   = 1'b0;
      busy_i_s = 1'b0;
      busy_d_s = 1'b0;
      case (state_r)
         IDLE:    idle_s   = 1'b1;
         BUSY_I:  busy_i_s = 1'b1;
         BUSY_D:  busy_d_s = 1'b1;
         default: idle_s   = 1'b1;
      endcase
   end

   // Completion detection and fixed-priority issue decision.
   always_comb begin
      done_i_s    = busy_i_s & cnt_zero_s;
      done_d_s    = busy_d_s & cnt_zero_s;
      can_issue_s = idle_s | done_i_s | done_d_s;
      issue_d_s   = can_issue_s & d_req;
      issue_i_s   = can_issue_s & ~d_req & if_req & ~if_flush;
      cnt_dec_s   = (busy_i_s | busy_d_s) & ~cnt_zero_s;
   end

   // Next state and kill flag; kill only survives while the same fetch is outstanding.
   always_comb begin
      state_nxt_s = state_r;
      kill_nxt_s  = 1'b0;
      if (issue_d_s) begin
         state_nxt_s = BUSY_D;
      end else if (issue_i_s) begin
         state_nxt_s = BUSY_I;
      end else if (can_issue_s) begin
         state_nxt_s = IDLE;
      end else begin
         state_nxt_s = state_r;
      end
      if (busy_i_s && !done_i_s) begin
         kill_nxt_s = kill_r | if_flush;
      end else begin
         kill_nxt_s = 1'b0;
      end
   end

   // FSM and kill registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
         kill_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         kill_r  <= kill_nxt_s;
      end
   end

   // Memory command mux, completion routing and stalls; everything forced low in reset.
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      mem_be    = BE_NONE;
      if_valid  = 1'b0;
      if_rdata  = {DATA_W{1'b0}};
      d_valid   = 1'b0;
      d_rdata   = {DATA_W{1'b0}};
      if_stall  = 1'b0;
      d_stall   = 1'b0;
      if (!rst_n) begin
         mem_en = 1'b0;
      end else begin
         if (issue_d_s) begin
            mem_en    = 1'b1;
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_be    = d_be;
         end else if (issue_i_s) begin
            mem_en    = 1'b1;
            mem_we    = 1'b0;
            mem_addr  = if_addr;
            mem_wdata = {DATA_W{1'b0}};
            mem_be    = BE_NONE;
         end else begin
            mem_en = 1'b0;
         end
         d_valid  = done_d_s;
         d_rdata  = done_d_s ? mem_rdata : {DATA_W{1'b0}};
         if_valid = done_i_s & ~(kill_r | if_flush);
         if_rdata = (done_i_s & ~(kill_r | if_flush)) ? mem_rdata : {DATA_W{1'b0}};
         if_stall = if_req & ~(done_i_s & ~(kill_r | if_flush));
         d_stall  = d_req & ~done_d_s;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench: transaction-level model for MEM_LAT=2, directed literals,
// plus a MEM_LAT=1 streaming instance.
module tb_mem_port_arbiter;

   localparam int LAT = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        if_req, if_flush, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [3:0]  d_be;
   logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
   logic        if_valid, if_stall, d_valid, d_stall, mem_en, mem_we;
   logic [3:0]  mem_be;

   logic        s_if_req, s_if_flush, s_d_req, s_d_we;
   logic [31:0] s_if_addr, s_d_addr, s_d_wdata;
   logic [3:0]  s_d_be;
   logic [31:0] s_if_rdata, s_d_rdata, s_mem_addr, s_mem_wdata, s_mem_rdata;
   logic        s_if_valid, s_if_stall, s_d_valid, s_d_stall, s_mem_en, s_mem_we;
   logic [3:0]  s_mem_be;

   int checks = 0;
   int errors = 0;
   int mcyc = 0;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .if_req(s_if_req), .if_addr(s_if_addr), .if_flush(s_if_flush),
      .if_rdata(s_if_rdata), .if_valid(s_if_valid), .if_stall(s_if_stall),
      .d_req(s_d_req), .d_we(s_d_we), .d_addr(s_d_addr), .d_wdata(s_d_wdata), .d_be(s_d_be),
      .d_rdata(s_d_rdata), .d_valid(s_d_valid), .d_stall(s_d_stall),
      .mem_en(s_mem_en), .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
      .mem_be(s_mem_be), .mem_rdata(s_mem_rdata)
   );

   function automatic logic [31:0] memval(input logic [31:0] a);
      if (a == 32'h0000_0100) return 32'h0050_0093;
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   // Memory models: read data appears LAT cycles after mem_en; stores return 0.
   logic        p1_v, p1_we, p2_v, p2_we, q_v, q_we;
   logic [31:0] p1_a, p2_a, q_a;
   always @(posedge clk) begin
      p1_v  <= mem_en;  p1_we <= mem_we;  p1_a <= mem_addr;
      p2_v  <= p1_v;    p2_we <= p1_we;   p2_a <= p1_a;
      q_v   <= s_mem_en; q_we <= s_mem_we; q_a <= s_mem_addr;
   end
   assign mem_rdata   = p2_v ? (p2_we ? 32'h0 : memval(p2_a)) : 32'hBADC_0FFE;
   assign s_mem_rdata = q_v ? (q_we ? 32'h0 : memval(q_a)) : 32'hBADC_0FFE;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %h expected %h", nm, mcyc, got, exp);
      end
   endtask

   // Transaction-level model state (owner: 0 none, 1 fetch, 2 data)
   int          m_owner = 0;
   int          m_done_at = 0;
   logic [31:0] m_addr = 32'h0;
   logic        m_we = 1'b0;
   logic        m_kill = 1'b0;
   logic        p_ok = 1'b0, p_if_stall = 1'b0, p_d_stall = 1'b0, p_if_flush = 1'b0;
   logic        p_if_req = 1'b0;
   logic [31:0] p_if_addr = 32'h0, p_d_addr = 32'h0, p_d_wdata = 32'h0;
   logic [5:0]  p_d_ctl = 6'h0;

   initial begin
      logic        comp, comp_i, comp_d, free;
      int          win;
      logic        e_mem_en, e_mem_we, e_if_valid, e_d_valid, e_if_stall, e_d_stall;
      logic [31:0] e_mem_addr, e_mem_wdata, e_if_rdata, e_d_rdata;
      logic [3:0]  e_mem_be;
      forever begin
         @(negedge clk);
         comp = 1'b0; comp_i = 1'b0; comp_d = 1'b0; win = 0;
         e_mem_en = 1'b0; e_mem_we = 1'b0; e_if_valid = 1'b0; e_d_valid = 1'b0;
         e_if_stall = 1'b0; e_d_stall = 1'b0; e_mem_addr = 32'h0; e_mem_wdata = 32'h0;
         e_if_rdata = 32'h0; e_d_rdata = 32'h0; e_mem_be = 4'h0;
         if (rst_n) begin
            comp   = (m_owner != 0) && (mcyc == m_done_at);
            comp_d = comp && (m_owner == 2);
            comp_i = comp && (m_owner == 1);
            e_d_valid  = comp_d;
            e_d_rdata  = comp_d ? (m_we ? 32'h0 : memval(m_addr)) : 32'h0;
            e_if_valid = comp_i && !(m_kill || if_flush);
            e_if_rdata = e_if_valid ? memval(m_addr) : 32'h0;
            free = (m_owner == 0) || comp;
            if (free && d_req) win = 2;
            else if (free && if_req && !if_flush) win = 1;
            else win = 0;
            e_mem_en    = (win != 0);
            e_mem_we    = (win == 2) && d_we;
            e_mem_addr  = (win == 2) ? d_addr : ((win == 1) ? if_addr : 32'h0);
            e_mem_wdata = (win == 2) ? d_wdata : 32'h0;
            e_mem_be    = (win == 2) ? d_be : 4'h0;
            e_if_stall  = if_req && !e_if_valid;
            e_d_stall   = d_req && !e_d_valid;
         end
         chk("mem_en", mem_en, e_mem_en);
         chk("mem_we", mem_we, e_mem_we);
         chk("if_valid", if_valid, e_if_valid);
         chk("if_rdata", if_rdata, e_if_rdata);
         chk("d_valid", d_valid, e_d_valid);
         chk("d_rdata", d_rdata, e_d_rdata);
         chk("if_stall", if_stall, e_if_stall);
         chk("d_stall", d_stall, e_d_stall);
         if (e_mem_en || !rst_n) begin
            chk("mem_addr", mem_addr, e_mem_addr);
            chk("mem_wdata", mem_wdata, e_mem_wdata);
            chk("mem_be", mem_be, e_mem_be);
         end
         // Requester hold rule: a stalled request may only change in its completion cycle.
         if (rst_n && p_ok && p_d_stall && !comp_d) begin
            chk("d_hold_ctl", {d_req, d_we, d_be}, p_d_ctl);
            chk("d_hold_addr", d_addr, p_d_addr);
            chk("d_hold_wdata", d_wdata, p_d_wdata);
         end
         if (rst_n && p_ok && p_if_stall && !comp_i && !p_if_flush) begin
            chk("if_hold_req", if_req, p_if_req);
            chk("if_hold_addr", if_addr, p_if_addr);
         end
         if (!rst_n) begin
            m_owner = 0; m_kill = 1'b0;
         end else if (win != 0) begin
            m_owner = win; m_done_at = mcyc + LAT; m_kill = 1'b0;
            m_addr = (win == 2) ? d_addr : if_addr;
            m_we = (win == 2) && d_we;
         end else if (comp) begin
            m_owner = 0; m_kill = 1'b0;
         end else if (m_owner == 1 && if_flush) begin
            m_kill = 1'b1;
         end else begin
            m_kill = m_kill;
         end
         p_ok = rst_n; p_if_stall = e_if_stall; p_d_stall = e_d_stall; p_if_flush = if_flush;
         p_if_req = if_req; p_if_addr = if_addr;
         p_d_ctl = {d_req, d_we, d_be}; p_d_addr = d_addr; p_d_wdata = d_wdata;
         mcyc++;
      end
   end

   task automatic drv(input logic r, input logic ir, input logic [31:0] ia, input logic fl,
                      input logic dr, input logic we, input logic [31:0] da,
                      input logic [31:0] wd, input logic [3:0] be);
      rst_n = r; if_req = ir; if_addr = ia; if_flush = fl;
      d_req = dr; d_we = we; d_addr = da; d_wdata = wd; d_be = be;
   endtask

   task automatic idle();
      drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int dv_seen;
      s_if_req = 1'b0; s_if_addr = 32'h0; s_if_flush = 1'b0; s_d_req = 1'b0;
      s_d_we = 1'b0; s_d_addr = 32'h0; s_d_wdata = 32'h0; s_d_be = 4'h0;
      // Reset with both requests asserted: every output must stay low
      drv(1'b0, 1'b1, 32'h100, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0);
      #2;
      chk("rst_mem_en", mem_en, 32'h0);
      chk("rst_if_stall", if_stall, 32'h0);
      chk("rst_d_stall", d_stall, 32'h0);
      tick(); tick(); tick();
      idle(); tick();

      // Single fetch
      drv(1'b1, 1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #2;
      chk("f_mem_en0", mem_en, 32'h1); chk("f_addr0", mem_addr, 32'h100); chk("f_stall0", if_stall, 32'h1);
      tick(); #2;
      chk("f_mem_en1", mem_en, 32'h0); chk("f_stall1", if_stall, 32'h1);
      tick();
      idle(); #2;
      chk("f_valid2", if_valid, 32'h1); chk("f_rdata2", if_rdata, 32'h0050_0093); chk("f_stall2", if_stall, 32'h0);
      tick(); tick();

      // Collision: data first, fetch issued in the data completion cycle
      drv(1'b1, 1'b1, 32'h104, 1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 4'h0); #2;
      chk("c_addr0", mem_addr, 32'h2000); chk("c_we0", mem_we, 32'h0); chk("c_istall0", if_stall, 32'h1);
      tick(); tick();
      drv(1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #2;
      chk("c_dvalid2", d_valid, 32'h1); chk("c_drdata2", d_rdata, 32'h7A5A_DFFF);
      chk("c_mem_en2", mem_en, 32'h1); chk("c_addr2", mem_addr, 32'h104);
      tick(); #2;
      chk("c_ivalid3", if_valid, 32'h0);
      tick();
      idle(); #2;
      chk("c_ivalid4", if_valid, 32'h1); chk("c_irdata4", if_rdata, 32'h5B5E_FEFB);
      tick(); tick();

      // Store
      drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 4'b0011); #2;
      chk("s_we0", mem_we, 32'h1); chk("s_be0", mem_be, 32'h3); chk("s_wdata0", mem_wdata, 32'hDEAD_BEEF);
      tick(); #2;
      chk("s_dvalid1", d_valid, 32'h0);
      tick();
      idle(); #2;
      chk("s_dvalid2", d_valid, 32'h1); chk("s_drdata2", d_rdata, 32'h0);
      tick(); tick();

      // Flush of an outstanding fetch, next fetch issued in its completion cycle
      drv(1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); tick();
      drv(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); tick();
      drv(1'b1, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #2;
      chk("fl_ivalid2", if_valid, 32'h0); chk("fl_mem_en2", mem_en, 32'h1); chk("fl_addr2", mem_addr, 32'h300);
      tick(); tick();
      idle(); #2;
      chk("fl_ivalid4", if_valid, 32'h1); chk("fl_rdata4", if_rdata, 32'h595A_FCFF);
      tick();

      // Flush in IDLE blocks issue for that cycle only
      drv(1'b1, 1'b1, 32'h400, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #2;
      chk("fi_mem_en0", mem_en, 32'h0);
      tick();
      drv(1'b1, 1'b1, 32'h400, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #2;
      chk("fi_mem_en1", mem_en, 32'h1);
      tick(); tick();
      idle(); #2;
      chk("fi_ivalid3", if_valid, 32'h1);
      tick();

      // Flush in the completion cycle itself suppresses if_valid
      drv(1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); tick(); tick();
      drv(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #2;
      chk("fc_ivalid2", if_valid, 32'h0);
      tick();
      idle(); tick();

      // Reset in the middle of a load
      drv(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h2008, 32'h0, 4'h0); tick();
      drv(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h2008, 32'h0, 4'h0); #2;
      chk("rm_mem_en", mem_en, 32'h0); chk("rm_dstall", d_stall, 32'h0);
      chk("rm_dvalid", d_valid, 32'h0); chk("rm_drdata", d_rdata, 32'h0);
      tick();
      dv_seen = 0;
      for (int i = 0; i < 6; i++) begin
         idle(); #2;
         if (d_valid) dv_seen++;
         tick();
      end
      chk("rm_no_dvalid", dv_seen, 32'h0);

      // MEM_LAT=1 streaming: eight back-to-back fetches
      for (int k = 0; k < 10; k++) begin
         s_if_req  = (k < 8);
         s_if_addr = (k < 8) ? (32'h1000 + 32'(4 * k)) : 32'h0;
         #2;
         chk("st_mem_en", s_mem_en, (k < 8) ? 32'h1 : 32'h0);
         chk("st_ivalid", s_if_valid, (k >= 1 && k <= 8) ? 32'h1 : 32'h0);
         if (k >= 1 && k <= 8) chk("st_rdata", s_if_rdata, memval(32'h1000 + 32'(4 * (k - 1))));
         if (k < 8) chk("st_addr", s_mem_addr, 32'h1000 + 32'(4 * k));
         tick();
      end

      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
